// File: rtl/wt_dcache_miss_arb.sv
// Miss arbiter for the write-through dcache: picks one controller miss at a time,
// tracks outstanding misses per port, promotes starving low-priority ports and drains on flush.
module wt_dcache_miss_arb #(
  parameter int NumPorts     = 4,
  parameter int NumHiPrio    = 2,
  parameter int MaxOutst     = 4,
  parameter int StarveCycles = 16,
  parameter int PlenWidth    = 56,
  parameter int IdWidth      = 2,
  localparam int PortW       = $clog2(NumPorts)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                flush_i,
  output logic                                flush_ack_o,
  input  logic [NumPorts-1:0]                 req_i,
  output logic [NumPorts-1:0]                 ack_o,
  input  logic [NumPorts-1:0][PlenWidth-1:0]  paddr_i,
  input  logic [NumPorts-1:0][63:0]           wdata_i,
  input  logic [NumPorts-1:0]                 we_i,
  input  logic [NumPorts-1:0]                 nc_i,
  input  logic [NumPorts-1:0][2:0]            size_i,
  input  logic [NumPorts-1:0][IdWidth-1:0]    id_i,
  output logic                                miss_req_o,
  input  logic                                miss_ack_i,
  output logic [PlenWidth-1:0]                miss_paddr_o,
  output logic [63:0]                         miss_wdata_o,
  output logic                                miss_we_o,
  output logic                                miss_nc_o,
  output logic [2:0]                          miss_size_o,
  output logic [IdWidth-1:0]                  miss_id_o,
  output logic [PortW-1:0]                    miss_port_o,
  input  logic                                rtrn_vld_i,
  input  logic [PortW-1:0]                    rtrn_port_i,
  output logic [NumPorts-1:0]                 rtrn_vld_o,
  output logic                                busy_o,
  output logic                                err_o,
  output logic [1:0]                          dbg_state_o
);

  localparam int         NumLo     = NumPorts - NumHiPrio;
  localparam logic [3:0] MaxCnt    = 4'(MaxOutst);
  localparam logic [7:0] StarveMax = 8'(StarveCycles);

  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, DRAIN = 2'd2} state_e;

  state_e               state_q, state_d;
  logic [PortW-1:0]     gnt_q, rr_q, rr_next, sel_idx;
  logic                 sel_valid;
  logic [3:0]           cnt_q  [NumPorts];
  logic [7:0]           wait_q [NumPorts];
  logic [NumPorts-1:0]  elig, promoted;
  logic                 all_zero, err_q, err_set, flush_done_q;

  always_comb begin
    all_zero = 1'b1;
    for (int i = 0; i < NumPorts; i++) begin
      elig[i]     = req_i[i] && (cnt_q[i] < MaxCnt) && !flush_i && (state_q != DRAIN);
      promoted[i] = (i >= NumHiPrio) && (wait_q[i] == StarveMax);
      if (cnt_q[i] != 4'd0) all_zero = 1'b0;
    end
  end

  // Priority: promoted low ports, then fixed high ports, then round-robin over low ports.
  always_comb begin
    int idx;
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < NumPorts; i++) begin
      if (!sel_valid && elig[i] && promoted[i]) begin
        sel_valid = 1'b1;
        sel_idx   = PortW'(i);
      end
    end
    for (int i = 0; i < NumHiPrio; i++) begin
      if (!sel_valid && elig[i]) begin
        sel_valid = 1'b1;
        sel_idx   = PortW'(i);
      end
    end
    for (int off = 0; off < NumLo; off++) begin
      idx = int'(rr_q) + off;
      if (idx >= NumPorts) idx = idx - NumLo;
      if (!sel_valid && elig[idx]) begin
        sel_valid = 1'b1;
        sel_idx   = PortW'(idx);
      end
    end
  end

  always_comb begin
    int g1;
    g1      = int'(gnt_q) + 1;
    rr_next = (g1 >= NumPorts) ? PortW'(NumHiPrio) : PortW'(g1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (flush_i) state_d = DRAIN;
               else if (sel_valid) state_d = GRANT;
      GRANT:   if (miss_ack_i) state_d = flush_i ? DRAIN : IDLE;
      DRAIN:   if (all_zero) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake: miss_req_o is held with stable miss_* fields until miss_ack_i is seen
  // high in the same cycle; that cycle is the transfer and pulses ack_o of the locked port.
  always_comb begin
    ack_o       = '0;
    miss_req_o  = (state_q == GRANT) && !rst_i;
    if (miss_req_o && miss_ack_i) ack_o[gnt_q] = 1'b1;
    flush_ack_o = (state_q == DRAIN) && all_zero && !flush_done_q && !rst_i;
    busy_o      = (!all_zero || (state_q == GRANT)) && !rst_i;
    err_o       = err_q;
    dbg_state_o = state_q;
  end

  always_comb begin
    miss_paddr_o = paddr_i[gnt_q];
    miss_wdata_o = wdata_i[gnt_q];
    miss_we_o    = we_i[gnt_q];
    miss_nc_o    = nc_i[gnt_q];
    miss_size_o  = size_i[gnt_q];
    miss_id_o    = id_i[gnt_q];
    miss_port_o  = gnt_q;
  end

  always_comb begin
    rtrn_vld_o = '0;
    if (rtrn_vld_i) rtrn_vld_o[rtrn_port_i] = 1'b1;
  end

  always_comb begin
    err_set = (state_q == GRANT) && !req_i[gnt_q];
    for (int i = 0; i < NumPorts; i++) begin
      if (rtrn_vld_o[i] && !ack_o[i] && (cnt_q[i] == 4'd0)) err_set = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gnt_q        <= '0;
      rr_q         <= PortW'(NumHiPrio);
      err_q        <= 1'b0;
      flush_done_q <= 1'b0;
      for (int i = 0; i < NumPorts; i++) begin
        cnt_q[i]  <= 4'd0;
        wait_q[i] <= 8'd0;
      end
    end else begin
      if ((state_q == IDLE) && (state_d == GRANT)) gnt_q <= sel_idx;
      if ((state_q == GRANT) && miss_ack_i && (int'(gnt_q) >= NumHiPrio)) rr_q <= rr_next;
      if (err_set) err_q <= 1'b1;
      // Remembers that this flush was already acknowledged while flush_i stays high.
      flush_done_q <= flush_i && (flush_done_q || flush_ack_o);
      for (int i = 0; i < NumPorts; i++) begin
        if (ack_o[i] && !rtrn_vld_o[i] && (cnt_q[i] < MaxCnt)) cnt_q[i] <= cnt_q[i] + 4'd1;
        else if (rtrn_vld_o[i] && !ack_o[i] && (cnt_q[i] != 4'd0)) cnt_q[i] <= cnt_q[i] - 4'd1;
        if (i >= NumHiPrio) begin
          if (ack_o[i]) wait_q[i] <= 8'd0;
          else if (elig[i] && (wait_q[i] < StarveMax)) wait_q[i] <= wait_q[i] + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_wt_dcache_miss_arb.sv
// Directed bench for wt_dcache_miss_arb: decode table plus hand-written multi-cycle sequences
// for round-robin, starvation, outstanding limit, flush drain, reset and error cases.
module tb_wt_dcache_miss_arb;

  logic             clk = 1'b0;
  logic             rst_i, flush_i, flush_ack_o;
  logic [3:0]       req_i, ack_o;
  logic [3:0][55:0] paddr_i;
  logic [3:0][63:0] wdata_i;
  logic [3:0]       we_i, nc_i;
  logic [3:0][2:0]  size_i;
  logic [3:0][1:0]  id_i;
  logic             miss_req_o, miss_ack_i;
  logic [55:0]      miss_paddr_o;
  logic [63:0]      miss_wdata_o;
  logic             miss_we_o, miss_nc_o;
  logic [2:0]       miss_size_o;
  logic [1:0]       miss_id_o, miss_port_o;
  logic             rtrn_vld_i;
  logic [1:0]       rtrn_port_i;
  logic [3:0]       rtrn_vld_o;
  logic             busy_o, err_o;
  logic [1:0]       dbg_state_o;

  wt_dcache_miss_arb dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .flush_ack_o(flush_ack_o),
    .req_i(req_i), .ack_o(ack_o), .paddr_i(paddr_i), .wdata_i(wdata_i),
    .we_i(we_i), .nc_i(nc_i), .size_i(size_i), .id_i(id_i),
    .miss_req_o(miss_req_o), .miss_ack_i(miss_ack_i), .miss_paddr_o(miss_paddr_o),
    .miss_wdata_o(miss_wdata_o), .miss_we_o(miss_we_o), .miss_nc_o(miss_nc_o),
    .miss_size_o(miss_size_o), .miss_id_o(miss_id_o), .miss_port_o(miss_port_o),
    .rtrn_vld_i(rtrn_vld_i), .rtrn_port_i(rtrn_port_i), .rtrn_vld_o(rtrn_vld_o),
    .busy_o(busy_o), .err_o(err_o), .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       vld;
    logic [1:0] port;
    logic [3:0] exp_vld;
  } vec_t;

  vec_t       vecs [6];
  logic [1:0] exp_q [$];
  int         checks = 0;
  int         failures = 0;
  int         pend, pend_port, got, last, n, p0n, p2_cyc, pulses, pcyc, gnts;

  function automatic logic [55:0] addr_of(input int p);
    return 56'h00_1234_0000_0000 + 56'(p) * 56'h100;
  endfunction

  function automatic int oh_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic clear_inputs();
    req_i = '0; flush_i = 1'b0; miss_ack_i = 1'b0; rtrn_vld_i = 1'b0; rtrn_port_i = '0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    clear_inputs();
    @(posedge clk);
    @(posedge clk); #1;
    rst_i = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    for (int p = 0; p < 4; p++) begin
      paddr_i[p] = addr_of(p);
      wdata_i[p] = 64'hDEAD_0000_0000_0000 | 64'(p);
      size_i[p]  = 3'(p + 1);
      id_i[p]    = 2'(3 - p);
    end
    we_i = 4'b0101;
    nc_i = 4'b1010;
    vecs[0] = '{1'b0, 2'd0, 4'b0000};
    vecs[1] = '{1'b1, 2'd0, 4'b0001};
    vecs[2] = '{1'b1, 2'd1, 4'b0010};
    vecs[3] = '{1'b1, 2'd2, 4'b0100};
    vecs[4] = '{1'b1, 2'd3, 4'b1000};
    vecs[5] = '{1'b0, 2'd3, 4'b0000};

    // reset values
    rst_i = 1'b1;
    clear_inputs();
    next_cycle();
    @(negedge clk);
    check("rst_miss_req", miss_req_o, 0);
    check("rst_ack", ack_o, 0);
    check("rst_flush_ack", flush_ack_o, 0);
    check("rst_busy", busy_o, 0);
    next_cycle();
    rst_i = 1'b0;
    @(negedge clk);
    check("rst_err", err_o, 0);
    check("rst_state_idle", dbg_state_o, 0);
    check("rst_idle_no_req", miss_req_o, 0);

    // round robin between two low-priority ports, immediate returns
    do_reset();
    req_i = 4'b1100; miss_ack_i = 1'b1;
    exp_q.push_back(2'd2); exp_q.push_back(2'd3); exp_q.push_back(2'd2); exp_q.push_back(2'd3);
    pend = 0; pend_port = 0; last = -1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      rtrn_vld_i = 1'(pend); rtrn_port_i = 2'(pend_port);
      @(negedge clk);
      pend = 0;
      if (ack_o != 4'b0) begin
        got = oh_idx(ack_o);
        check("rr_queue_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("rr_grant_port", got, exp_q.pop_front());
        if (last >= 0) check("rr_grant_gap", cyc - last, 2);
        else check("rr_first_ack_cycle", cyc, 1);
        last = cyc; pend = 1; pend_port = got;
      end
      next_cycle();
    end
    check("rr_all_granted", exp_q.size(), 0);
    exp_q.delete();

    // starvation promotion of port 2 against high-priority port 0
    do_reset();
    req_i = 4'b0101; miss_ack_i = 1'b1;
    pend = 0; pend_port = 0; p0n = 0; p2_cyc = -1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      rtrn_vld_i = 1'(pend); rtrn_port_i = 2'(pend_port);
      @(negedge clk);
      pend = 0;
      if (ack_o != 4'b0) begin
        got = oh_idx(ack_o);
        pend = 1; pend_port = got;
        if (got == 2 && p2_cyc < 0) p2_cyc = cyc;
        if (got == 0 && p2_cyc < 0) p0n++;
      end
      next_cycle();
    end
    check("starve_p2_ack_cycle", p2_cyc, 17);
    check("starve_p0_acks_before", p0n, 8);

    // outstanding limit on port 0 with no returns
    do_reset();
    req_i = 4'b0001; miss_ack_i = 1'b1; n = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (ack_o[0]) n++;
      next_cycle();
    end
    @(negedge clk);
    check("maxoutst_ack_count", n, 4);
    check("maxoutst_req_low", miss_req_o, 0);
    check("maxoutst_busy", busy_o, 1);
    next_cycle();
    req_i = 4'b0; rtrn_vld_i = 1'b1; rtrn_port_i = 2'd0;
    repeat (4) next_cycle();
    rtrn_vld_i = 1'b0;
    @(negedge clk);
    check("maxoutst_drained_busy", busy_o, 0);
    check("maxoutst_no_err", err_o, 0);

    // flush with two misses outstanding on port 1
    do_reset();
    req_i = 4'b0010; miss_ack_i = 1'b1; n = 0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      if (ack_o[1]) n++;
      next_cycle();
    end
    check("flush_setup_acks", n, 2);
    req_i = 4'b0001; flush_i = 1'b1;
    pulses = 0; pcyc = -1; gnts = 0; p0n = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      rtrn_vld_i = (cyc == 5 || cyc == 9); rtrn_port_i = 2'd1;
      if (cyc == 15) flush_i = 1'b0;
      @(negedge clk);
      if (flush_ack_o) begin pulses++; pcyc = cyc; end
      if (cyc <= 14 && miss_req_o) gnts++;
      if (cyc > 14 && ack_o[0]) p0n++;
      next_cycle();
    end
    check("flush_pulse_count", pulses, 1);
    check("flush_pulse_cycle", pcyc, 10);
    check("flush_no_grants", gnts, 0);
    check("flush_resume_grant", p0n > 0, 1);

    // ack and return on port 3 in the same cycle with count 1
    do_reset();
    req_i = 4'b1000; miss_ack_i = 1'b1;
    next_cycle();
    @(negedge clk); check("same_cyc_setup_ack", ack_o, 4'b1000); next_cycle();
    next_cycle();
    rtrn_vld_i = 1'b1; rtrn_port_i = 2'd3;
    @(negedge clk); check("same_cyc_ack", ack_o, 4'b1000); next_cycle();
    req_i = 4'b0; rtrn_vld_i = 1'b0;
    @(negedge clk); check("same_cyc_count_kept", busy_o, 1); next_cycle();
    rtrn_vld_i = 1'b1;
    next_cycle();
    rtrn_vld_i = 1'b0;
    @(negedge clk);
    check("same_cyc_final_return", busy_o, 0);
    check("same_cyc_no_err", err_o, 0);

    // locked port drops its request before ack; fields follow the locked port
    do_reset();
    req_i = 4'b0100; miss_ack_i = 1'b0;
    next_cycle();
    @(negedge clk);
    check("grant_req", miss_req_o, 1);
    check("grant_port", miss_port_o, 2);
    check("grant_paddr", miss_paddr_o, addr_of(2));
    check("grant_wdata", miss_wdata_o, 64'hDEAD_0000_0000_0002);
    check("grant_we_nc", {miss_we_o, miss_nc_o}, 2'b10);
    check("grant_size_id", {miss_size_o, miss_id_o}, 5'b011_01);
    next_cycle();
    req_i = 4'b0;
    @(negedge clk); check("drop_err_not_yet", err_o, 0); check("drop_still_req", miss_req_o, 1); next_cycle();
    miss_ack_i = 1'b1;
    @(negedge clk); check("drop_err_set", err_o, 1); check("drop_ack_completes", ack_o, 4'b0100); next_cycle();
    miss_ack_i = 1'b0;
    @(negedge clk); check("drop_back_idle", miss_req_o, 0);

    // reset in the middle of a grant
    do_reset();
    req_i = 4'b0010; miss_ack_i = 1'b0;
    next_cycle();
    @(negedge clk); check("rst_mid_grant_req", miss_req_o, 1); next_cycle();
    rst_i = 1'b1; miss_ack_i = 1'b1;
    @(negedge clk);
    check("rst_mid_grant_no_ack", ack_o, 0);
    check("rst_mid_grant_req_low", miss_req_o, 0);
    next_cycle();
    rst_i = 1'b0; miss_ack_i = 1'b0; req_i = 4'b0;
    @(negedge clk);
    check("rst_mid_grant_busy", busy_o, 0);
    check("rst_mid_grant_idle", dbg_state_o, 0);
    check("rst_mid_grant_err", err_o, 0);

    // return decode table, also returning to empty counters
    do_reset();
    @(negedge clk); check("decode_err_before", err_o, 0); next_cycle();
    foreach (vecs[k]) begin
      rtrn_vld_i = vecs[k].vld; rtrn_port_i = vecs[k].port;
      @(negedge clk);
      check("rtrn_decode", rtrn_vld_o, vecs[k].exp_vld);
      next_cycle();
    end
    rtrn_vld_i = 1'b0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk); check("err_sticky", err_o, 1); check("err_count_zero", busy_o, 0); next_cycle();
    end
    do_reset();
    @(negedge clk); check("err_cleared_by_reset", err_o, 0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
